// File: rtl/psg_write_sequencer.sv
// Drives the Mockingboard's two YM2149 PSGs directly on BDIR/BC/DI, one bus phase per PSG ce pulse.
// Two round-robin requesters share the bus; a mute command writes zero to all six amplitude registers.
module psg_write_sequencer #(
  parameter int GAP_PHASES = 1
) (
  input  logic        clk_logic,
  input  logic        reset,
  input  logic        ce,
  input  logic        enable,
  input  logic [1:0]  req_valid,
  input  logic [7:0]  req_reg,
  input  logic [15:0] req_data,
  input  logic [1:0]  req_chip,
  output logic [1:0]  req_ready,
  input  logic        mute_req,
  output logic        mute_done,
  output logic        psg_bdir_l,
  output logic        psg_bc_l,
  output logic        psg_bdir_r,
  output logic        psg_bc_r,
  output logic [7:0]  psg_di,
  output logic        busy
);

  typedef enum logic [2:0] {S_IDLE, S_LATCH, S_GAP, S_WRITE, S_HOLD} state_t;

  localparam logic [1:0] GAP_LAST = 2'(GAP_PHASES - 1);

  state_t      r_state;
  logic [1:0]  r_gap_cnt;
  logic [3:0]  r_reg;
  logic [7:0]  r_data;
  logic        r_chip;
  logic        r_last_grant;
  logic        r_mute_pending;
  logic        r_mute_active;
  logic [2:0]  r_mute_idx;
  logic        r_mute_done;
  logic        r_bdir_l, r_bc_l, r_bdir_r, r_bc_r;
  logic [7:0]  r_di;

  state_t      w_next_state;
  logic [1:0]  w_next_gap;
  logic [1:0]  w_grant;
  logic        w_pick;
  logic        w_mute_start;
  logic        w_mute_cont;
  logic        w_mute_end;
  logic [2:0]  w_mute_idx_n;
  logic [3:0]  w_sel_reg;
  logic [7:0]  w_sel_data;
  logic        w_sel_chip;
  logic        w_bus_bdir;
  logic        w_bus_bc;

  // Mute write i targets amplitude register 8+(i%3); writes 0..2 go left, 3..5 go right.
  function automatic logic [3:0] mute_reg(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd3: return 4'd8;
      3'd1, 3'd4: return 4'd9;
      default:    return 4'd10;
    endcase
  endfunction

  // Tie goes to the requester not granted last; otherwise the lone valid one.
  assign w_pick = (&req_valid) ? ~r_last_grant : req_valid[1];

  // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_next_state = r_state;
    w_next_gap   = r_gap_cnt;
    w_grant      = 2'b00;
    w_mute_start = 1'b0;
    w_mute_cont  = 1'b0;
    w_mute_end   = 1'b0;
    if (ce) begin
      unique case (r_state)
        S_IDLE, S_HOLD: begin
          w_mute_end = (r_state == S_HOLD) && r_mute_active && (r_mute_idx == 3'd5);
          if (r_mute_active && (r_mute_idx != 3'd5)) begin
            w_mute_cont  = 1'b1;
            w_next_state = S_LATCH;
          end else if (r_mute_pending || mute_req) begin
            w_mute_start = 1'b1;
            w_next_state = S_LATCH;
          end else if (enable && (|req_valid)) begin
            w_grant      = w_pick ? 2'b10 : 2'b01;
            w_next_state = S_LATCH;
          end else begin
            w_next_state = S_IDLE;
          end
        end
        S_LATCH: begin
          w_next_state = S_GAP;
          w_next_gap   = 2'd0;
        end
        S_GAP: begin
          if (r_gap_cnt == GAP_LAST) w_next_state = S_WRITE;
          else                       w_next_gap   = r_gap_cnt + 2'd1;
        end
        S_WRITE: w_next_state = S_HOLD;
        default: w_next_state = S_IDLE;
      endcase
    end
  end

  assign w_mute_idx_n = w_mute_start ? 3'd0 : r_mute_idx + 3'd1;

  always_comb begin
    w_sel_reg  = r_reg;
    w_sel_data = r_data;
    w_sel_chip = r_chip;
    if (w_mute_start || w_mute_cont) begin
      w_sel_reg  = mute_reg(w_mute_idx_n);
      w_sel_data = 8'h00;
      w_sel_chip = (w_mute_idx_n >= 3'd3);
    end else if (w_grant[1]) begin
      w_sel_reg  = req_reg[7:4];
      w_sel_data = req_data[15:8];
      w_sel_chip = req_chip[1];
    end else if (w_grant[0]) begin
      w_sel_reg  = req_reg[3:0];
      w_sel_data = req_data[7:0];
      w_sel_chip = req_chip[0];
    end
  end

  assign w_bus_bdir = (w_next_state == S_LATCH) || (w_next_state == S_WRITE);
  assign w_bus_bc   = (w_next_state == S_LATCH);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_logic) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_gap_cnt      <= 2'd0;
      r_reg          <= 4'd0;
      r_data         <= 8'd0;
      r_chip         <= 1'b0;
      r_last_grant   <= 1'b1;
      r_mute_pending <= 1'b0;
      r_mute_active  <= 1'b0;
      r_mute_idx     <= 3'd0;
      r_mute_done    <= 1'b0;
      r_bdir_l       <= 1'b0;
      r_bc_l         <= 1'b0;
      r_bdir_r       <= 1'b0;
      r_bc_r         <= 1'b0;
      r_di           <= 8'd0;
    end else begin
      r_state     <= w_next_state;
      r_gap_cnt   <= w_next_gap;
      r_mute_done <= w_mute_end;

      if (|w_grant) r_last_grant <= w_pick;

      if (w_mute_start)  r_mute_pending <= 1'b0;
      else if (mute_req) r_mute_pending <= 1'b1;

      if (w_mute_start) begin
        r_mute_active <= 1'b1;
        r_mute_idx    <= w_mute_idx_n;
      end else if (w_mute_cont) begin
        r_mute_idx    <= w_mute_idx_n;
      end else if (w_mute_end) begin
        r_mute_active <= 1'b0;
      end

      if (w_mute_start || w_mute_cont || (|w_grant)) begin
        r_reg  <= w_sel_reg;
        r_data <= w_sel_data;
        r_chip <= w_sel_chip;
      end

      if (ce) begin
        r_bdir_l <= w_bus_bdir & ~w_sel_chip;
        r_bc_l   <= w_bus_bc   & ~w_sel_chip;
        r_bdir_r <= w_bus_bdir &  w_sel_chip;
        r_bc_r   <= w_bus_bc   &  w_sel_chip;
        // DI keeps its last value through GAP, HOLD and IDLE.
        if (w_next_state == S_LATCH)      r_di <= {4'b0000, w_sel_reg};
        else if (w_next_state == S_WRITE) r_di <= r_data;
      end
    end
  end

  assign req_ready  = w_grant;
  assign mute_done  = r_mute_done;
  assign psg_bdir_l = r_bdir_l;
  assign psg_bc_l   = r_bc_l;
  assign psg_bdir_r = r_bdir_r;
  assign psg_bc_r   = r_bc_r;
  assign psg_di     = r_di;
  assign busy       = (r_state != S_IDLE) || r_mute_pending;

endmodule

// File: tb/tb_psg_write_sequencer.sv
// Bench for psg_write_sequencer: vector table for single writes, directed sequences for arbitration,
// mute, enable gating, reset mid-write, and a GAP_PHASES=3 instance.
module tb_psg_write_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ce = 1'b0;
  always #5 clk = ~clk;

  // Instance A: default gap
  logic        en_a = 1'b0, mute_req_a = 1'b0;
  logic [1:0]  valid_a = 2'b00, chip_a = 2'b00;
  logic [7:0]  reg_a = 8'h00;
  logic [15:0] data_a = 16'h0000;
  logic [1:0]  ready_a;
  logic        mute_done_a, bdir_l_a, bc_l_a, bdir_r_a, bc_r_a, busy_a;
  logic [7:0]  di_a;

  // Instance B: GAP_PHASES = 3, used for the mute double-pulse test
  logic        en_b = 1'b0, mute_req_b = 1'b0;
  logic [1:0]  valid_b = 2'b00, chip_b = 2'b00;
  logic [7:0]  reg_b = 8'h00;
  logic [15:0] data_b = 16'h0000;
  logic [1:0]  ready_b;
  logic        mute_done_b, bdir_l_b, bc_l_b, bdir_r_b, bc_r_b, busy_b;
  logic [7:0]  di_b;

  psg_write_sequencer dut_a (
    .clk_logic(clk), .reset(reset), .ce(ce), .enable(en_a),
    .req_valid(valid_a), .req_reg(reg_a), .req_data(data_a), .req_chip(chip_a),
    .req_ready(ready_a), .mute_req(mute_req_a), .mute_done(mute_done_a),
    .psg_bdir_l(bdir_l_a), .psg_bc_l(bc_l_a), .psg_bdir_r(bdir_r_a), .psg_bc_r(bc_r_a),
    .psg_di(di_a), .busy(busy_a)
  );

  psg_write_sequencer #(.GAP_PHASES(3)) dut_b (
    .clk_logic(clk), .reset(reset), .ce(ce), .enable(en_b),
    .req_valid(valid_b), .req_reg(reg_b), .req_data(data_b), .req_chip(chip_b),
    .req_ready(ready_b), .mute_req(mute_req_b), .mute_done(mute_done_b),
    .psg_bdir_l(bdir_l_b), .psg_bc_l(bc_l_b), .psg_bdir_r(bdir_r_b), .psg_bc_r(bc_r_b),
    .psg_di(di_b), .busy(busy_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  typedef struct {logic id; int at;} grant_t;
  grant_t       grants_a[$];
  logic [16:0]  wlog_a[$];   // {chip, latched address, written data}
  int           sep_b[$];    // ce pulses from LATCH to WRITE on instance B
  int           ce_n = 0;
  int           mdone_a = 0, mdone_b = 0, ready_no_ce = 0;
  logic [7:0]   lat_a = 8'h00;
  int           lat_at_b = 0;

  always @(negedge clk) begin
    if (ce) begin
      if (ready_a != 2'b00) grants_a.push_back('{ready_a[1], ce_n});
      if (bdir_l_a && bc_l_a)  lat_a = di_a;
      if (bdir_r_a && bc_r_a)  lat_a = di_a;
      if (bdir_l_a && !bc_l_a) wlog_a.push_back({1'b0, lat_a, di_a});
      if (bdir_r_a && !bc_r_a) wlog_a.push_back({1'b1, lat_a, di_a});
      if ((bdir_l_b && bc_l_b) || (bdir_r_b && bc_r_b)) lat_at_b = ce_n;
      if ((bdir_l_b && !bc_l_b) || (bdir_r_b && !bc_r_b)) sep_b.push_back(ce_n - lat_at_b);
      ce_n++;
    end else if (ready_a != 2'b00 || ready_b != 2'b00) begin
      ready_no_ce++;
    end
    if (mute_done_a) mdone_a++;
    if (mute_done_b) mdone_b++;
  end

  // ---------------- stimulus helpers ----------------
  logic [1:0] rdy_a;

  // One ce pulse followed by two quiet clocks; entered and left #1 after a rising edge.
  task automatic pulse();
    ce = 1'b1;
    @(negedge clk);
    rdy_a = ready_a;
    @(posedge clk); #1;
    ce = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  valid;
    logic [7:0]  rg;
    logic [15:0] dat;
    logic [1:0]  chip;
    logic [1:0]  e_ready;
    logic [3:0]  e_bus;   // {bdir_l, bc_l, bdir_r, bc_r}
    logic [7:0]  e_di;
    logic        e_busy;
  } vec_t;

  vec_t        vec [10];
  logic [16:0] exp_w [8];
  int          base, wbase, mbase, gbase;
  logic        busy_seen;

  initial begin
    // Left write reg 7 <- 0x38 via req0, then right write reg 3 <- 0xA5 via req1.
    vec[0] = '{2'b01, 8'h07, 16'h0038, 2'b00, 2'b01, 4'b1100, 8'h07, 1'b1};
    vec[1] = '{2'b00, 8'h07, 16'h0038, 2'b00, 2'b00, 4'b0000, 8'h07, 1'b1};
    vec[2] = '{2'b00, 8'h07, 16'h0038, 2'b00, 2'b00, 4'b1000, 8'h38, 1'b1};
    vec[3] = '{2'b00, 8'h07, 16'h0038, 2'b00, 2'b00, 4'b0000, 8'h38, 1'b1};
    vec[4] = '{2'b00, 8'h07, 16'h0038, 2'b00, 2'b00, 4'b0000, 8'h38, 1'b0};
    vec[5] = '{2'b10, 8'h30, 16'hA500, 2'b10, 2'b10, 4'b0011, 8'h03, 1'b1};
    vec[6] = '{2'b00, 8'h30, 16'hA500, 2'b10, 2'b00, 4'b0000, 8'h03, 1'b1};
    vec[7] = '{2'b00, 8'h30, 16'hA500, 2'b10, 2'b00, 4'b0010, 8'hA5, 1'b1};
    vec[8] = '{2'b00, 8'h30, 16'hA500, 2'b10, 2'b00, 4'b0000, 8'hA5, 1'b1};
    vec[9] = '{2'b00, 8'h30, 16'hA500, 2'b10, 2'b00, 4'b0000, 8'hA5, 1'b0};

    exp_w[0] = {1'b1, 8'h02, 8'h11};
    exp_w[1] = {1'b0, 8'h08, 8'h00};
    exp_w[2] = {1'b0, 8'h09, 8'h00};
    exp_w[3] = {1'b0, 8'h0A, 8'h00};
    exp_w[4] = {1'b1, 8'h08, 8'h00};
    exp_w[5] = {1'b1, 8'h09, 8'h00};
    exp_w[6] = {1'b1, 8'h0A, 8'h00};
    exp_w[7] = {1'b0, 8'h05, 8'h77};

    @(posedge clk); #1;
    do_reset();

    // Reset state
    check("rst_bus", {bdir_l_a, bc_l_a, bdir_r_a, bc_r_a}, 4'b0000);
    check("rst_di", di_a, 8'h00);
    check("rst_busy", busy_a, 1'b0);
    check("rst_mute_done", mute_done_a, 1'b0);
    check("rst_ready", ready_a, 2'b00);

    // Vector table: single writes on each chip
    en_a = 1'b1;
    for (int i = 0; i < 10; i++) begin
      valid_a = vec[i].valid;
      reg_a   = vec[i].rg;
      data_a  = vec[i].dat;
      chip_a  = vec[i].chip;
      pulse();
      check($sformatf("v%0d_ready", i), rdy_a, vec[i].e_ready);
      check($sformatf("v%0d_bus", i), {bdir_l_a, bc_l_a, bdir_r_a, bc_r_a}, vec[i].e_bus);
      check($sformatf("v%0d_di", i), di_a, vec[i].e_di);
      check($sformatf("v%0d_busy", i), busy_a, vec[i].e_busy);
    end

    // Both requesters held valid: grants alternate 0,1,0,1, four ce pulses apart
    do_reset();
    valid_a = 2'b11; reg_a = 8'h21; data_a = 16'hBBAA; chip_a = 2'b10;
    gbase = grants_a.size();
    for (int i = 0; i < 40; i++) begin
      pulse();
      if (grants_a.size() >= gbase + 4) break;
    end
    valid_a = 2'b00;
    check("alt_count", grants_a.size() - gbase, 4);
    for (int i = 0; i < 4; i++) begin
      if (gbase + i < grants_a.size()) begin
        check($sformatf("alt_id%0d", i), grants_a[gbase+i].id, (i % 2 == 1));
        if (i > 0)
          check($sformatf("alt_gap%0d", i), grants_a[gbase+i].at - grants_a[gbase+i-1].at, 4);
      end
    end
    repeat (5) pulse();

    // Mute requested mid-write of req1; req0 waits for the whole mute sequence
    do_reset();
    reg_a = 8'h25; data_a = 16'h1177; chip_a = 2'b10;
    valid_a = 2'b10;
    wbase = wlog_a.size();
    mbase = mdone_a;
    pulse();
    check("mute_req1_ready", rdy_a, 2'b10);
    valid_a = 2'b00;
    mute_req_a = 1'b1;
    @(posedge clk); #1;
    mute_req_a = 1'b0;
    valid_a = 2'b01;
    for (int i = 0; i < 80; i++) begin
      pulse();
      if (rdy_a[0]) valid_a = 2'b00;
      if (wlog_a.size() >= wbase + 8) break;
    end
    valid_a = 2'b00;
    repeat (3) pulse();
    check("mute_wr_count", wlog_a.size() - wbase, 8);
    for (int i = 0; i < 8; i++)
      if (wbase + i < wlog_a.size()) check($sformatf("mute_wr%0d", i), wlog_a[wbase+i], exp_w[i]);
    check("mute_done_count", mdone_a - mbase, 1);

    // enable=0 blocks grants and busy stays low; raising it grants at the next ce
    do_reset();
    en_a = 1'b0; valid_a = 2'b01; reg_a = 8'h01; data_a = 16'h0042; chip_a = 2'b00;
    gbase = grants_a.size();
    busy_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      pulse();
      busy_seen |= busy_a;
    end
    check("en0_grants", grants_a.size() - gbase, 0);
    check("en0_busy", busy_seen, 1'b0);
    en_a = 1'b1;
    pulse();
    check("en1_ready", rdy_a, 2'b01);
    valid_a = 2'b00;
    repeat (5) pulse();

    // Reset during WRITE: outputs clear next clock and the write is never replayed
    do_reset();
    valid_a = 2'b01; reg_a = 8'h04; data_a = 16'h0099; chip_a = 2'b00;
    pulse();
    valid_a = 2'b00;
    pulse();
    pulse();
    check("rmw_in_write", {bdir_l_a, bc_l_a, di_a}, {2'b10, 8'h99});
    wbase = wlog_a.size();
    reset = 1'b1;
    @(posedge clk); #1;
    check("rmw_bus", {bdir_l_a, bc_l_a, bdir_r_a, bc_r_a}, 4'b0000);
    check("rmw_di", di_a, 8'h00);
    check("rmw_busy", busy_a, 1'b0);
    reset = 1'b0;
    repeat (6) pulse();
    check("rmw_no_replay", wlog_a.size() - wbase, 0);

    // GAP_PHASES=3: LATCH->WRITE is 4 ce; a second mute_req during a mute yields two mute_done
    do_reset();
    mbase = mdone_b;
    base  = sep_b.size();
    mute_req_b = 1'b1;
    @(posedge clk); #1;
    mute_req_b = 1'b0;
    for (int i = 0; i < 150; i++) begin
      pulse();
      if (i == 10) begin
        mute_req_b = 1'b1;
        @(posedge clk); #1;
        mute_req_b = 1'b0;
      end
      if (mdone_b - mbase >= 2) break;
    end
    repeat (20) pulse();
    check("gap3_mute_done", mdone_b - mbase, 2);
    check("gap3_writes", sep_b.size() - base, 12);
    if (sep_b.size() > base) check("gap3_sep", sep_b[base], 4);

    check("ready_without_ce", ready_no_ce, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
